// File: rtl/hmac_req_if.sv
// Handshake bundle between the host, the HMAC request sequencer and the HMAC engine.
// The slave modport is the sequencer's view; the master modport is the host/engine side.
interface hmac_req_if;
  logic         req_valid;
  logic         req_ready;
  logic [511:0] req_key;
  logic [511:0] req_data;
  logic [255:0] req_tag;
  logic         eng_go;
  logic [511:0] eng_key;
  logic [511:0] eng_data;
  logic [255:0] eng_hmac;
  logic         eng_data_available;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [255:0] rsp_hmac;
  logic         rsp_match;
  logic         rsp_timeout;
  logic         busy;

  modport slave (
    input  req_valid, req_key, req_data, req_tag, eng_hmac, eng_data_available, rsp_ready,
    output req_ready, eng_go, eng_key, eng_data, rsp_valid, rsp_hmac, rsp_match, rsp_timeout, busy
  );

  modport master (
    output req_valid, req_key, req_data, req_tag, eng_hmac, eng_data_available, rsp_ready,
    input  req_ready, eng_go, eng_key, eng_data, rsp_valid, rsp_hmac, rsp_match, rsp_timeout, busy
  );
endinterface

// File: rtl/hmac_req.sv
// HmacReq: accepts one host request, launches the HMAC engine, waits for a fresh
// result (low-then-high on eng_data_available), compares it to the expected tag and
// presents a held response until the host takes it.
// Optional feature: define HMAC_REQ_TIMEOUT_EN to bound the wait for the engine by
// TIMEOUT_CYCLES; without it the block waits forever and rsp_timeout is tied low.
module hmac_req #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic        CLK,
  input logic        RST,
  hmac_req_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GO        = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [511:0] key_q, key_d;
  logic [511:0] data_q, data_d;
  logic [255:0] tag_q, tag_d;
  logic [255:0] hmac_q, hmac_d;
  logic         match_q, match_d;

`ifdef HMAC_REQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`else
  logic unusedTimeoutCfg;
  assign unusedTimeoutCfg = (TIMEOUT_CYCLES > 0);
`endif

  // State and datapath registers; reset aborts any request in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      key_q     <= '0;
      data_q    <= '0;
      tag_q     <= '0;
      hmac_q    <= '0;
      match_q   <= 1'b0;
`ifdef HMAC_REQ_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      data_q    <= data_d;
      tag_q     <= tag_d;
      hmac_q    <= hmac_d;
      match_q   <= match_d;
`ifdef HMAC_REQ_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Next-state logic: latch request, pulse engine, wait for a fresh result, then respond.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    data_d    = data_q;
    tag_d     = tag_q;
    hmac_d    = hmac_q;
    match_d   = match_q;
`ifdef HMAC_REQ_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          key_d   = bus.req_key;
          data_d  = bus.req_data;
          tag_d   = bus.req_tag;
          state_d = GO;
        end
      end
      GO: begin
        state_d = WAIT_LOW;
`ifdef HMAC_REQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT_LOW: begin
`ifdef HMAC_REQ_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
        if (!bus.eng_data_available) begin
          state_d = WAIT_HIGH;
        end else if (cnt_q == CNT_MAX) begin
          hmac_d    = '0;
          match_d   = 1'b0;
          timeout_d = 1'b1;
          state_d   = RESP;
        end
`else
        if (!bus.eng_data_available) begin
          state_d = WAIT_HIGH;
        end
`endif
      end
      WAIT_HIGH: begin
`ifdef HMAC_REQ_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (bus.eng_data_available) begin
          hmac_d  = bus.eng_hmac;
          match_d = (bus.eng_hmac == tag_q);
`ifdef HMAC_REQ_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d = RESP;
        end
`ifdef HMAC_REQ_TIMEOUT_EN
        else if (cnt_q == CNT_MAX) begin
          hmac_d    = '0;
          match_d   = 1'b0;
          timeout_d = 1'b1;
          state_d   = RESP;
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.eng_go    = (state_q == GO);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.busy      = (state_q != IDLE);
  assign bus.eng_key   = key_q;
  assign bus.eng_data  = data_q;
  assign bus.rsp_hmac  = hmac_q;
  assign bus.rsp_match = match_q;
`ifdef HMAC_REQ_TIMEOUT_EN
  assign bus.rsp_timeout = timeout_q;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hmac_req.sv
// Directed self-checking bench for hmac_req with a small HMAC engine model.
module tb_hmac_req;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  hmac_req_if bus();

  hmac_req #(.TIMEOUT_CYCLES(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int errors  = 0;

  // Engine model configuration
  logic [255:0] modelHmac  = '0;
  int           dropDelay  = 1;
  int           riseN      = 10;
  bit           modelNever = 1'b0;

  // Engine model: after eng_go, drops data_available dropDelay cycles later,
  // then raises it with modelHmac riseN cycles after that.
  initial begin : engineModel
    int phase;
    int cnt;
    phase = 0;
    cnt   = 0;
    bus.eng_data_available = 1'b0;
    bus.eng_hmac           = '0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        phase = 0;
      end else if (bus.eng_go) begin
        phase = 1;
        cnt   = 0;
      end else if (phase == 1) begin
        cnt++;
        if (cnt == dropDelay) begin
          bus.eng_data_available = 1'b0;
          phase = 2;
          cnt   = 0;
        end
      end else if (phase == 2) begin
        cnt++;
        if (!modelNever && cnt == riseN) begin
          bus.eng_data_available = 1'b1;
          bus.eng_hmac           = modelHmac;
          phase = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents one request and waits (bounded) for rsp_valid; lat counts rising edges
  // from the accepting edge up to and including the edge that raised rsp_valid.
  task automatic applyStimulus(input logic [511:0] k, input logic [511:0] d, input logic [255:0] t,
                               output int lat, output int goCnt);
    bus.req_key   = k;
    bus.req_data  = d;
    bus.req_tag   = t;
    bus.req_valid = 1'b1;
    goCnt = 0;
    tick();
    lat = 1;
    bus.req_valid = 1'b0;
    while (!bus.rsp_valid && lat < 100) begin
      if (bus.eng_go) goCnt++;
      tick();
      lat++;
    end
    if (!bus.rsp_valid) lat = -1;
  endtask

  localparam logic [511:0] KEY1  = {16{32'h0123_4567}};
  localparam logic [511:0] DATA1 = {16{32'h89AB_CDEF}};
  localparam logic [511:0] KEY2  = {16{32'hDEAD_BEEF}};
  localparam logic [511:0] DATA2 = {16{32'hFEED_F00D}};
  localparam logic [255:0] HA5   = {32{8'hA5}};
  localparam logic [255:0] HA4   = {{31{8'hA5}}, 8'hA4};
  localparam logic [255:0] H01   = {8{32'h0F1E_2D3C}};
  localparam logic [255:0] HC3   = {32{8'hC3}};

  initial begin : stimulus
    int lat;
    int goCnt;
    int stableBad;
    int busyLow;
    logic [255:0] heldHmac;

    bus.req_valid = 1'b0;
    bus.req_key   = '0;
    bus.req_data  = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    tick();
    tick();
    checkOutput("rst_req_ready", 512'(bus.req_ready), 512'(1'b1));
    checkOutput("rst_busy", 512'(bus.busy), 512'(1'b0));
    checkOutput("rst_rsp_valid", 512'(bus.rsp_valid), 512'(1'b0));
    checkOutput("rst_eng_go", 512'(bus.eng_go), 512'(1'b0));
    checkOutput("rst_rsp_hmac", 512'(bus.rsp_hmac), 512'(0));
    checkOutput("rst_rsp_match", 512'(bus.rsp_match), 512'(1'b0));
    checkOutput("rst_rsp_timeout", 512'(bus.rsp_timeout), 512'(1'b0));
    RST = 1'b1;
    tick();
    checkOutput("rel_req_ready", 512'(bus.req_ready), 512'(1'b1));

    // Matching tag, N=10
    modelHmac = HA5; dropDelay = 1; riseN = 10; modelNever = 1'b0;
    applyStimulus(KEY1, DATA1, HA5, lat, goCnt);
    checkOutput("match_latency", 512'(lat), 512'(13));
    checkOutput("match_go_count", 512'(goCnt), 512'(1));
    checkOutput("match_rsp_match", 512'(bus.rsp_match), 512'(1'b1));
    checkOutput("match_rsp_timeout", 512'(bus.rsp_timeout), 512'(1'b0));
    checkOutput("match_rsp_hmac", 512'(bus.rsp_hmac), 512'(HA5));
    checkOutput("match_eng_key", bus.eng_key, KEY1);
    checkOutput("match_eng_data", bus.eng_data, DATA1);
    checkOutput("match_req_ready_resp", 512'(bus.req_ready), 512'(1'b0));
    tick();
    checkOutput("match_back_idle", 512'(bus.req_ready), 512'(1'b1));
    checkOutput("match_rsp_dropped", 512'(bus.rsp_valid), 512'(1'b0));

    // LSB of tag flipped
    applyStimulus(KEY2, DATA2, HA4, lat, goCnt);
    checkOutput("mis_latency", 512'(lat), 512'(13));
    checkOutput("mis_rsp_match", 512'(bus.rsp_match), 512'(1'b0));
    checkOutput("mis_rsp_hmac", 512'(bus.rsp_hmac), 512'(HA5));
    checkOutput("mis_eng_key", bus.eng_key, KEY2);
    tick();

    // Minimum latency path
    modelHmac = H01; riseN = 1;
    applyStimulus(KEY1, DATA2, H01, lat, goCnt);
    checkOutput("min_latency", 512'(lat), 512'(4));
    checkOutput("min_rsp_match", 512'(bus.rsp_match), 512'(1'b1));
    checkOutput("min_rsp_hmac", 512'(bus.rsp_hmac), 512'(H01));
    tick();

    // Stale data_available high at go, dropped two cycles later
    modelHmac = HC3; dropDelay = 2; riseN = 5;
    applyStimulus(KEY2, DATA1, HC3, lat, goCnt);
    checkOutput("stale_latency", 512'(lat), 512'(9));
    checkOutput("stale_rsp_hmac", 512'(bus.rsp_hmac), 512'(HC3));
    checkOutput("stale_rsp_match", 512'(bus.rsp_match), 512'(1'b1));
    tick();

    // Response back-pressure with a competing request
    modelHmac = HA5; dropDelay = 1; riseN = 3;
    bus.rsp_ready = 1'b0;
    applyStimulus(KEY1, DATA1, HA4, lat, goCnt);
    checkOutput("bp_latency", 512'(lat), 512'(6));
    heldHmac = bus.rsp_hmac;
    checkOutput("bp_rsp_hmac", 512'(heldHmac), 512'(HA5));
    bus.req_key   = KEY2;
    bus.req_data  = DATA2;
    bus.req_valid = 1'b1;
    stableBad = 0;
    goCnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!bus.rsp_valid || bus.req_ready || bus.rsp_hmac !== heldHmac || bus.rsp_match !== 1'b0)
        stableBad++;
      if (bus.eng_go) goCnt++;
    end
    checkOutput("bp_stable_cycles", 512'(stableBad), 512'(0));
    checkOutput("bp_no_second_go", 512'(goCnt), 512'(0));
    checkOutput("bp_eng_key_held", bus.eng_key, KEY1);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    checkOutput("bp_released_idle", 512'(bus.busy), 512'(1'b0));
    tick();
    checkOutput("bp_no_extra_req", 512'(bus.busy), 512'(1'b0));

    // Engine never responds
    modelNever = 1'b1;
`ifdef HMAC_REQ_TIMEOUT_EN
    applyStimulus(KEY2, DATA2, HA5, lat, goCnt);
    checkOutput("to_latency", 512'(lat), 512'(17));
    checkOutput("to_rsp_timeout", 512'(bus.rsp_timeout), 512'(1'b1));
    checkOutput("to_rsp_match", 512'(bus.rsp_match), 512'(1'b0));
    checkOutput("to_rsp_hmac", 512'(bus.rsp_hmac), 512'(0));
    tick();
    bus.req_key   = KEY2;
    bus.req_data  = DATA2;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
`else
    bus.req_key   = KEY2;
    bus.req_data  = DATA2;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    busyLow = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!bus.busy || bus.rsp_valid) busyLow++;
    end
    checkOutput("hang_busy_held", 512'(busyLow), 512'(0));
`endif

    // Asynchronous reset while waiting for the result
    checkOutput("pre_rst_busy", 512'(bus.busy), 512'(1'b1));
    #2 RST = 1'b0;
    #1;
    checkOutput("arst_busy", 512'(bus.busy), 512'(1'b0));
    checkOutput("arst_req_ready", 512'(bus.req_ready), 512'(1'b1));
    checkOutput("arst_rsp_valid", 512'(bus.rsp_valid), 512'(1'b0));
    checkOutput("arst_eng_key", bus.eng_key, 512'(0));
    checkOutput("arst_eng_data", bus.eng_data, 512'(0));
    @(negedge CLK);
    modelNever = 1'b0;
    RST = 1'b1;
    tick();
    checkOutput("arst_rel_req_ready", 512'(bus.req_ready), 512'(1'b1));
    checkOutput("arst_rel_rsp_valid", 512'(bus.rsp_valid), 512'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
